// File: rtl/lsu_pkg.sv
// Shared types for the AXI4-Lite load/store unit: FSM states, access-size codes,
// AXI response codes and a size-to-byte-count helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_RESP
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 4'd1;
            SZ_H:    return 4'd2;
            SZ_W:    return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data/strobe placement and load
// data extraction with zero/sign extension, parametrised by bus width.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  i_woff,
    input  logic [1:0]        i_wsize,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    input  logic [OFF_W-1:0]  i_roff,
    input  logic [1:0]        i_rsize,
    input  logic              i_rsext,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [STRB_W-1:0] w_base;
    logic [DATA_W-1:0] w_shift;
    logic              w_sign;
    int                w_nbits;

    always_comb begin
        w_base = '0;
        for (int i = 0; i < STRB_W; i++) begin
            w_base[i] = (i < int'(size_bytes(i_wsize)));
        end
        o_wstrb = w_base << i_woff;
        o_wdata = i_wdata << {i_woff, 3'b000};
    end

    // Bits above the accessed size are replaced by the sign (or zero).
    always_comb begin
        w_shift = i_rdata >> {i_roff, 3'b000};
        w_nbits = 8 * int'(size_bytes(i_rsize));
        if (w_nbits > DATA_W) begin
            w_nbits = DATA_W;
        end
        w_sign = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == w_nbits - 1) begin
                w_sign = i_rsext & w_shift[i];
            end
        end
        o_rdata = '0;
        for (int i = 0; i < DATA_W; i++) begin
            o_rdata[i] = (i < w_nbits) ? w_shift[i] : w_sign;
        end
    end

endmodule

// File: rtl/lsu_axil.sv
// AXI4-Lite load/store unit: one outstanding access, lane alignment, error response.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them.
module lsu_axil
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [OFF_W-1:0]  r_off;
    logic [1:0]        r_size;
    logic              r_sext;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_err, r_aw_done, r_w_done;

    logic [OFF_W-1:0]  w_off_mask, w_off;
    logic              w_misalign, w_fault;
    logic [DATA_W-1:0] w_wdata_al, w_rdata_ext;
    logic [STRB_W-1:0] w_wstrb_al;

    assign w_off_mask = OFF_W'(size_bytes(req_size) - 4'd1);
    assign w_off      = req_addr[OFF_W-1:0] & ~w_off_mask;
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = (req_addr[OFF_W-1:0] & w_off_mask) != '0;
`else
    assign w_misalign = 1'b0;
`endif
    // Double-word access on a 32-bit bus can never be served.
    assign w_fault = ((req_size == SZ_D) && (DATA_W < 64)) || w_misalign;

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane (
        .i_woff  (w_off),
        .i_wsize (req_size),
        .i_wdata (req_wdata),
        .o_wdata (w_wdata_al),
        .o_wstrb (w_wstrb_al),
        .i_roff  (r_off),
        .i_rsize (r_size),
        .i_rsext (r_sext),
        .i_rdata (rdata),
        .o_rdata (w_rdata_ext)
    );

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_fault ? S_RESP : (req_wen ? S_WR_REQ : S_RD_ADDR);
                end
            end
            S_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) w_next = S_RESP;
            end
            S_WR_REQ: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if ((r_aw_done | awready) && (r_w_done | wready)) w_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) w_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_off     <= '0;
            r_size    <= SZ_B;
            r_sext    <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_addr    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    r_off     <= w_off;
                    r_size    <= req_size;
                    r_sext    <= req_sext;
                    r_wdata   <= w_wdata_al;
                    r_wstrb   <= w_wstrb_al;
                    r_rdata   <= '0;
                    r_err     <= w_fault;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end
                S_RD_DATA: if (rvalid) begin
                    r_err   <= (rresp != RESP_OKAY);
                    r_rdata <= (rresp != RESP_OKAY) ? '0 : w_rdata_ext;
                end
                S_WR_REQ: begin
                    if (awready) r_aw_done <= 1'b1;
                    if (wready)  r_w_done  <= 1'b1;
                end
                S_WR_RESP: if (bvalid) begin
                    r_err   <= (bresp != RESP_OKAY);
                    r_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign araddr     = r_addr;
    assign awaddr     = r_addr;
    assign wdata      = r_wdata;
    assign wstrb      = r_wstrb;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu_axil.sv
// Bench for lsu_axil: 32-bit unit against a request-level model with a
// delay-programmable slave, plus a 64-bit unit with directed literal vectors.
module tb_lsu_axil;

    typedef struct {
        logic [31:0] araddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        logic        bus;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0, req_sext = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, araddr, awaddr, wdata;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0, bresp = '0;
    logic [3:0]  wstrb;

    logic        d_req_valid = 1'b0, d_req_ready, d_req_wen = 1'b0, d_req_sext = 1'b0;
    logic [31:0] d_req_addr = '0, d_araddr, d_awaddr;
    logic [1:0]  d_req_size = '0;
    logic [63:0] d_req_wdata = '0, d_resp_rdata, d_wdata;
    logic        d_resp_valid, d_resp_err, d_arvalid, d_rready, d_awvalid, d_wvalid, d_bready;
    logic [7:0]  d_wstrb;
    logic        d_arready = 1'b1, d_rvalid = 1'b1, d_awready = 1'b1, d_wready = 1'b1, d_bvalid = 1'b1;
    logic [1:0]  d_rresp = 2'b00, d_bresp = 2'b00;
    logic [63:0] d_rdata = 64'h8123_4567_89AB_CDEF;

    int   errors = 0, checks = 0;
    int   cyc = 0, acc = 0, resp_cnt = 0;
    bit   exp_active = 1'b0;
    exp_t exp_cur;
    int   s_ard = 0, s_rdd = 0, s_awd = 0, s_wdd = 0, s_bd = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0, s_bresp = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_axil #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_size(req_size), .req_sext(req_sext), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    lsu_axil #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(d_req_valid), .req_ready(d_req_ready), .req_wen(d_req_wen), .req_addr(d_req_addr),
        .req_size(d_req_size), .req_sext(d_req_sext), .req_wdata(d_req_wdata),
        .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata), .resp_err(d_resp_err),
        .araddr(d_araddr), .arvalid(d_arvalid), .arready(d_arready),
        .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(d_rready),
        .awaddr(d_awaddr), .awvalid(d_awvalid), .awready(d_awready),
        .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
        .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Request-level model of one 32-bit access.
    function automatic exp_t model(input bit wen, input logic [31:0] addr, input logic [1:0] size,
                                   input bit sext, input logic [31:0] wd, input logic [31:0] rd,
                                   input logic [1:0] xresp, input int ard, input int rdd,
                                   input int awd, input int wdd, input int bd);
        exp_t e;
        int nb, off, sb;
        logic [63:0] v, m;
        bit fault;
        nb    = 1 << size;
        fault = (size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (addr % nb != 0) fault = 1'b1;
`endif
        off      = int'(addr % 4);
        off      = off - (off % nb);
        e.araddr = addr & 32'hFFFF_FFFC;
        e.wdata  = wd << (8 * off);
        sb       = ((1 << nb) - 1) << off;
        e.wstrb  = 4'(sb);
        m = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v = (64'(rd) >> (8 * off)) & m;
        if (sext && ((v >> (8 * nb - 1)) & 64'd1) != 64'd0) v = v | ~m;
        e.bus = !fault;
        e.err = fault || (xresp != 2'b00);
        e.rdata = (e.err || wen) ? 32'h0 : 32'(v);
        if (fault)    e.lat = 1;
        else if (wen) e.lat = 3 + ((awd > wdd) ? awd : wdd) + bd;
        else          e.lat = 3 + ard + rdd;
        return e;
    endfunction

    // Slave: each ready/valid rises once its channel has waited the programmed cycles.
    initial begin
        int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin arready = (ar_c >= s_ard); ar_c++; end else begin arready = 1'b0; ar_c = 0; end
            if (rready)  begin rvalid  = (r_c  >= s_rdd); r_c++;  end else begin rvalid  = 1'b0; r_c  = 0; end
            if (awvalid) begin awready = (aw_c >= s_awd); aw_c++; end else begin awready = 1'b0; aw_c = 0; end
            if (wvalid)  begin wready  = (w_c  >= s_wdd); w_c++;  end else begin wready  = 1'b0; w_c  = 0; end
            if (bready)  begin bvalid  = (b_c  >= s_bd);  b_c++;  end else begin bvalid  = 1'b0; b_c  = 0; end
            rdata = s_rdata; rresp = s_rresp; bresp = s_bresp;
        end
    end

    // Compare process for the 32-bit unit.
    initial begin
        forever begin
            @(negedge clk);
            if (req_valid && req_ready) acc = cyc;
            if (resp_valid) resp_cnt++;
            if (exp_active && !rst) begin
                if (!exp_cur.bus) chk("no_bus_valid", 64'({arvalid, awvalid, wvalid}), 64'd0);
                if (arvalid) chk("araddr", 64'(araddr), 64'(exp_cur.araddr));
                if (awvalid) chk("awaddr", 64'(awaddr), 64'(exp_cur.araddr));
                if (wvalid) begin
                    chk("wdata", 64'(wdata), 64'(exp_cur.wdata));
                    chk("wstrb", 64'(wstrb), 64'(exp_cur.wstrb));
                end
                if (resp_valid) begin
                    chk("resp_rdata", 64'(resp_rdata), 64'(exp_cur.rdata));
                    chk("resp_err", 64'(resp_err), 64'(exp_cur.err));
                    chk("resp_cycle", 64'(cyc - acc), 64'(exp_cur.lat));
                end
            end
        end
    end

    task automatic run(input bit wen, input logic [31:0] addr, input logic [1:0] size, input bit sext,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] xresp,
                       input int ard, input int rdd, input int awd, input int wdd, input int bd,
                       input bit spam);
        int n;
        exp_cur = model(wen, addr, size, sext, wd, rd, xresp, ard, rdd, awd, wdd, bd);
        s_ard = ard; s_rdd = rdd; s_awd = awd; s_wdd = wdd; s_bd = bd;
        s_rdata = rd; s_rresp = xresp; s_bresp = xresp;
        resp_cnt = 0;
        exp_active = 1'b1;
        req_wen = wen; req_addr = addr; req_size = size; req_sext = sext; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        if (spam) begin
            req_addr = 32'hDEAD_BEE0; req_wen = ~wen; req_wdata = 32'h5555_AAAA;
        end else begin
            req_valid = 1'b0;
        end
        n = 0;
        while (!resp_valid && n < 60) begin @(posedge clk); #1; n++; end
        req_valid = 1'b0;
        chk("resp_seen", 64'(resp_valid), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("resp_count", 64'(resp_cnt), 64'd1);
        exp_active = 1'b0;
    endtask

    task automatic run64(input bit wen, input logic [31:0] addr, input logic [1:0] size, input bit sext,
                         input logic [63:0] wd, input logic [31:0] e_addr, input logic [7:0] e_strb,
                         input logic [63:0] e_wdata, input logic [63:0] e_rdata);
        int n;
        d_req_wen = wen; d_req_addr = addr; d_req_size = size; d_req_sext = sext; d_req_wdata = wd;
        d_req_valid = 1'b1;
        @(posedge clk); #1;
        d_req_valid = 1'b0;
        if (wen) begin
            chk("d_aw_w_valid", 64'({d_awvalid, d_wvalid}), 64'd3);
            chk("d_awaddr", 64'(d_awaddr), 64'(e_addr));
            chk("d_wstrb", 64'(d_wstrb), 64'(e_strb));
            chk("d_wdata", d_wdata, e_wdata);
        end else begin
            chk("d_arvalid", 64'(d_arvalid), 64'd1);
            chk("d_araddr", 64'(d_araddr), 64'(e_addr));
        end
        n = 1;
        while (!d_resp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("d_resp_cycle", 64'(n), 64'd3);
        chk("d_resp_rdata", d_resp_rdata, e_rdata);
        chk("d_resp_err", 64'(d_resp_err), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t p;
        int n;
        p = model(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0, 32'h80AB_CDEF, 2'b00, 0, 0, 0, 0, 0);
        chk("pin_lb_rdata", 64'(p.rdata), 64'hFFFF_FF80);
        chk("pin_lb_araddr", 64'(p.araddr), 64'h8000_0000);
        chk("pin_lb_lat", 64'(p.lat), 64'd3);
        p = model(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h1234, 32'h0, 2'b00, 0, 0, 3, 0, 0);
        chk("pin_sh_wdata", 64'(p.wdata), 64'h1234_0000);
        chk("pin_sh_wstrb", 64'(p.wstrb), 64'hC);
        p = model(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 2'b10, 0, 0, 0, 0, 0);
        chk("pin_rerr", 64'({p.err, p.rdata}), 64'h1_0000_0000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, resp_valid}), 64'd0);
        chk("rst_resp", 64'({resp_err, resp_rdata}), 64'd0);
        chk("rst_wstrb", 64'(wstrb), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        //   wen   addr           sz    sx    wdata          rdata          xresp ard rdd awd wdd bd spam
        run(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0,         32'h80AB_CDEF, 2'b00, 0, 0, 0, 0, 0, 1'b0);
        chk("lit_lb_rdata", 64'(resp_rdata), 64'hFFFF_FF80);
        run(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234, 32'h0,         2'b00, 0, 0, 3, 0, 0, 1'b0);
        run(1'b0, 32'h8000_0008, 2'd2, 1'b0, 32'h0,         32'h1234_5678, 2'b10, 0, 0, 0, 0, 0, 1'b0);
        run(1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'h0,         32'hCAFE_BABE, 2'b00, 1, 0, 0, 0, 0, 1'b0);
        run(1'b0, 32'h8000_0000, 2'd3, 1'b0, 32'h0,         32'h1111_2222, 2'b00, 0, 0, 0, 0, 0, 1'b0);
        run(1'b0, 32'h8000_0006, 2'd1, 1'b0, 32'h0,         32'h9876_5432, 2'b00, 2, 1, 0, 0, 0, 1'b1);
        run(1'b1, 32'h8000_0001, 2'd0, 1'b0, 32'h0000_005A, 32'h0,         2'b00, 0, 0, 0, 2, 1, 1'b0);
        run(1'b1, 32'h8000_0004, 2'd2, 1'b0, 32'hA5A5_0F0F, 32'h0,         2'b11, 0, 0, 1, 1, 2, 1'b0);
        run(1'b0, 32'h8000_0000, 2'd1, 1'b1, 32'h0,         32'h0000_8001, 2'b00, 0, 0, 0, 0, 0, 1'b0);
        run(1'b1, 32'h8000_0000, 2'd3, 1'b0, 32'hFFFF_FFFF, 32'h0,         2'b00, 0, 0, 0, 0, 0, 1'b0);

        // Reset while waiting for read data: transaction is dropped silently.
        exp_cur = model(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 32'h0, 2'b00, 0, 20, 0, 0, 0);
        s_ard = 0; s_rdd = 20; exp_active = 1'b1; resp_cnt = 0;
        req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rready && n < 10) begin @(posedge clk); #1; n++; end
        chk("rd_data_reached", 64'(rready), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ar_r", 64'({arvalid, rready}), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        s_rdd = 0;
        repeat (25) @(posedge clk);
        #1;
        chk("midrst_no_resp", 64'(resp_cnt), 64'd0);
        exp_active = 1'b0;
        run(1'b0, 32'h8000_0014, 2'd2, 1'b1, 32'h0, 32'h8765_4321, 2'b00, 0, 0, 0, 0, 0, 1'b0);

        run64(1'b1, 32'h10, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 32'h10, 8'hFF, 64'h1122_3344_5566_7788, 64'h0);
        run64(1'b0, 32'h18, 2'd3, 1'b1, 64'h0, 32'h18, 8'h00, 64'h0, 64'h8123_4567_89AB_CDEF);
        run64(1'b0, 32'h14, 2'd2, 1'b1, 64'h0, 32'h10, 8'h00, 64'h0, 64'hFFFF_FFFF_8123_4567);
        run64(1'b0, 32'h16, 2'd1, 1'b0, 64'h0, 32'h10, 8'h00, 64'h0, 64'h0000_0000_0000_8123);
        run64(1'b0, 32'h13, 2'd0, 1'b1, 64'h0, 32'h10, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF89);
        run64(1'b1, 32'h15, 2'd0, 1'b0, 64'hA5,  32'h10, 8'h20, 64'h0000_A500_0000_0000, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
